// File: rtl/event_encoder_pkg.sv
// Shared widths, types and helpers for the 8-to-3 event encoder.
package event_encoder_pkg;
    localparam int W = 3;
    localparam int N = 2 ** W;

    typedef logic [W-1:0] idx_t;
    typedef logic [N-1:0] vec_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Rotate right: result[j] = v[(j + s) mod N], so bit s lands at position 0.
    function automatic vec_t rotr(vec_t v, idx_t s);
        vec_t r;
        for (int j = 0; j < N; j++) begin
            r[j] = v[idx_t'(idx_t'(j) + s)];
        end
        return r;
    endfunction
endpackage

// File: rtl/event_encoder_8_to_3_if.sv
// Event-in / index-out bundle between sources, the encoder and the consumer.
interface event_encoder_8_to_3_if;
    import event_encoder_pkg::*;

    vec_t in;
    idx_t out;
    logic valid;
    logic ready;
    vec_t pending;
    logic overflow;

    modport master (
        input  in,
        input  ready,
        output out,
        output valid,
        output pending,
        output overflow
    );

    modport slave (
        output in,
        output ready,
        input  out,
        input  valid,
        input  pending,
        input  overflow
    );
endinterface

// File: rtl/rr_select_8.sv
// Round-robin pick: first set bit of pending at or above ptr, wrapping 7 -> 0.
module rr_select_8
    import event_encoder_pkg::*;
(
    input  vec_t pending,
    input  idx_t ptr,
    output logic any,
    output idx_t sel
);

    vec_t rot;
    idx_t k;

    always_comb begin
        rot = rotr(pending, ptr);
        k   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                k = idx_t'(j);
            end
        end
    end

    assign any = |pending;
    assign sel = k + ptr;

endmodule

// File: rtl/event_encoder_8_to_3.sv
// Latches event pulses, arbitrates round-robin and presents one index per
// valid/ready handshake.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | valid=0, nothing presented on out
// ST_FULL  | valid=1, out holds an unconsumed event index
module event_encoder_8_to_3
    import event_encoder_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    event_encoder_8_to_3_if.master bus
);

    state_t state_q, state_d;
    vec_t   pending_q, pending_d, clr;
    idx_t   out_q, ptr_q, sel;
    logic   ovf_q, ovf_d, any, load;

    rr_select_8 u_sel (
        .pending (pending_q),
        .ptr     (ptr_q),
        .any     (any),
        .sel     (sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (bus.ready && !any) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // A new pulse on the index being cleared wins over the clear and is not
    // counted as an overflow.
    always_comb begin
        load = any && ((state_q == ST_EMPTY) || bus.ready);
        clr  = '0;
        if (load) begin
            clr[sel] = 1'b1;
        end
        pending_d = bus.in | (pending_q & ~clr);
        ovf_d     = |(bus.in & pending_q & ~clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            out_q     <= '0;
            ptr_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            if (load) begin
                out_q <= sel;
                ptr_q <= sel + idx_t'(1);
            end
        end
    end

    assign bus.out      = out_q;
    assign bus.valid    = (state_q == ST_FULL);
    assign bus.pending  = pending_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_event_encoder_8_to_3.sv
// Directed bench for the 8-to-3 event encoder.
module tb_event_encoder_8_to_3;
    import event_encoder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    event_encoder_8_to_3_if bus ();

    event_encoder_8_to_3 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        bus.in    = '0;
        bus.ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.in    = 8'hFF;
        bus.ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.valid !== 1'b0 || bus.out !== 3'd0 || bus.pending !== 8'h00 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b out=%0d pending=%h ovf=%b, want 0/0/00/0",
                     bus.valid, bus.out, bus.pending, bus.overflow);
        end
        bus.in = '0;
        reset  = 1'b0;
        step();
        checks++;
        if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignores_in: pending=%h valid=%b, want 00/0", bus.pending, bus.valid);
        end
    endtask

    task automatic test_single();
        apply_reset();
        bus.ready = 1'b1;
        bus.in    = 8'h10;
        step();
        bus.in = '0;
        checks++;
        if (bus.pending !== 8'h10 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL single_t1: pending=%h valid=%b, want 10/0", bus.pending, bus.valid);
        end
        step();
        checks++;
        if (bus.valid !== 1'b1 || bus.out !== 3'd4 || bus.pending !== 8'h00) begin
            errors++;
            $display("FAIL single_t2: valid=%b out=%0d pending=%h, want 1/4/00",
                     bus.valid, bus.out, bus.pending);
        end
        step();
        checks++;
        if (bus.valid !== 1'b0 || bus.out !== 3'd4 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL single_t3: valid=%b out=%0d ovf=%b, want 0/4/0",
                     bus.valid, bus.out, bus.overflow);
        end
    endtask

    task automatic test_burst();
        apply_reset();
        bus.ready = 1'b1;
        bus.in    = 8'hFF;
        step();
        bus.in = '0;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.out !== idx_t'(i)) begin
                errors++;
                $display("FAIL burst_seq[%0d]: valid=%b out=%0d, want 1/%0d", i, bus.valid, bus.out, i);
            end
            step();
        end
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            errors++;
            $display("FAIL burst_end: valid=%b pending=%h, want 0/00", bus.valid, bus.pending);
        end
        // ptr must be back at 0: index 0 is chosen ahead of 7
        bus.in = 8'h81;
        step();
        bus.in = '0;
        step();
        checks++;
        if (bus.out !== 3'd0 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL burst_ptr_first: out=%0d valid=%b, want 0/1", bus.out, bus.valid);
        end
        step();
        checks++;
        if (bus.out !== 3'd7 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL burst_ptr_second: out=%0d valid=%b, want 7/1", bus.out, bus.valid);
        end
        step();
    endtask

    task automatic test_rr_wrap();
        idx_t exp_order [3];
        exp_order[0] = 3'd6;
        exp_order[1] = 3'd0;
        exp_order[2] = 3'd2;
        apply_reset();
        bus.ready = 1'b1;
        bus.in    = 8'h20;
        step();
        bus.in = '0;
        step();
        checks++;
        if (bus.out !== 3'd5 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_prime: out=%0d valid=%b, want 5/1", bus.out, bus.valid);
        end
        step();
        bus.in = 8'b0100_0101;
        step();
        bus.in = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.out !== exp_order[i]) begin
                errors++;
                $display("FAIL wrap_order[%0d]: valid=%b out=%0d, want 1/%0d",
                         i, bus.valid, bus.out, exp_order[i]);
            end
            step();
        end
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: valid=%b, want 0", bus.valid);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.ready = 1'b0;
        bus.in    = 8'h08;
        step();
        bus.in = '0;
        step();
        checks++;
        if (bus.valid !== 1'b1 || bus.out !== 3'd3) begin
            errors++;
            $display("FAIL bp_show: valid=%b out=%0d, want 1/3", bus.valid, bus.out);
        end
        bus.in = 8'h02;
        step();
        bus.in = '0;
        checks++;
        if (bus.overflow !== 1'b0 || bus.out !== 3'd3 || bus.pending !== 8'h02) begin
            errors++;
            $display("FAIL bp_first_pulse: ovf=%b out=%0d pending=%h, want 0/3/02",
                     bus.overflow, bus.out, bus.pending);
        end
        step();
        bus.in = 8'h02;
        step();
        bus.in = '0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.out !== 3'd3 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_overflow: ovf=%b out=%0d valid=%b, want 1/3/1",
                     bus.overflow, bus.out, bus.valid);
        end
        step();
        checks++;
        if (bus.overflow !== 1'b0 || bus.out !== 3'd3 || bus.pending !== 8'h02) begin
            errors++;
            $display("FAIL bp_ovf_pulse_end: ovf=%b out=%0d pending=%h, want 0/3/02",
                     bus.overflow, bus.out, bus.pending);
        end
        bus.ready = 1'b1;
        step();
        checks++;
        if (bus.valid !== 1'b1 || bus.out !== 3'd1) begin
            errors++;
            $display("FAIL bp_release: valid=%b out=%0d, want 1/1", bus.valid, bus.out);
        end
        step();
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            errors++;
            $display("FAIL bp_once: valid=%b pending=%h, want 0/00", bus.valid, bus.pending);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        bus.ready = 1'b1;
        bus.in    = 8'h04;
        step();
        bus.in = 8'h04;
        step();
        bus.in = '0;
        checks++;
        if (bus.valid !== 1'b1 || bus.out !== 3'd2 || bus.pending !== 8'h04 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL collide_first: valid=%b out=%0d pending=%h ovf=%b, want 1/2/04/0",
                     bus.valid, bus.out, bus.pending, bus.overflow);
        end
        step();
        checks++;
        if (bus.valid !== 1'b1 || bus.out !== 3'd2 || bus.pending !== 8'h00) begin
            errors++;
            $display("FAIL collide_second: valid=%b out=%0d pending=%h, want 1/2/00",
                     bus.valid, bus.out, bus.pending);
        end
        step();
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL collide_end: valid=%b, want 0", bus.valid);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.ready = 1'b0;
        bus.in    = 8'h01;
        step();
        bus.in = 8'h0C;
        step();
        bus.in = '0;
        checks++;
        if (bus.valid !== 1'b1 || bus.pending !== 8'h0C || bus.out !== 3'd0) begin
            errors++;
            $display("FAIL areset_setup: valid=%b pending=%h out=%0d, want 1/0C/0",
                     bus.valid, bus.pending, bus.out);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            errors++;
            $display("FAIL areset_immediate: valid=%b pending=%h, want 0/00", bus.valid, bus.pending);
        end
        step();
        reset     = 1'b0;
        bus.ready = 1'b1;
        bus.in    = 8'h80;
        step();
        bus.in = '0;
        step();
        checks++;
        if (bus.valid !== 1'b1 || bus.out !== 3'd7) begin
            errors++;
            $display("FAIL areset_after: valid=%b out=%0d, want 1/7", bus.valid, bus.out);
        end
        step();
    endtask

    initial begin
        reset     = 1'b1;
        bus.in    = '0;
        bus.ready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_rr_wrap();
        test_backpressure();
        test_collision();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
